apb_id_regfile: RTL

APB_ID_REGFILE -- requirements
Module: apb_id_regfile

---
 rtl/apb_id_regfile.sv | 116 +++++++++++
 1 files changed

// File: rtl/apb_id_regfile.sv
// APB slave exposing constant ID words, a read/write SCRATCH word and a
// self-counting RDCOUNT word, with a configurable number of wait states.
module apb_id_regfile #(
    parameter int                         DATA_W      = 16,
    parameter int                         NUM_ID      = 4,
    parameter logic [NUM_ID*DATA_W-1:0]   ID_INIT     = {16'h0000, 16'h0002, 16'h0001, 16'hA2F5},
    parameter int                         WAIT_STATES = 0,
    parameter int                         ADDR_W      = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int                IDX_W   = ADDR_W - 2;
    localparam logic [IDX_W-1:0]  SCR_IDX = IDX_W'(NUM_ID);
    localparam logic [IDX_W-1:0]  RDC_IDX = IDX_W'(NUM_ID + 1);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_write;
    logic              r_err;
    logic [DATA_W-1:0] r_scratch;
    logic [DATA_W-1:0] r_rdcount;

    logic [IDX_W-1:0]  w_idx;
    logic              w_misal;
    logic              w_is_id;
    logic              w_is_scr;
    logic              w_is_rdc;
    logic              w_err;
    logic [DATA_W-1:0] w_id_word;
    logic [DATA_W-1:0] w_rdata;

    assign w_idx    = PADDR[ADDR_W-1:2];
    assign w_misal  = |PADDR[1:0];
    assign w_is_id  = !w_misal && (w_idx < SCR_IDX);
    assign w_is_scr = !w_misal && (w_idx == SCR_IDX);
    assign w_is_rdc = !w_misal && (w_idx == RDC_IDX);
    // Only SCRATCH accepts writes; reads succeed on any mapped, aligned word.
    assign w_err    = PWRITE ? !w_is_scr : !(w_is_id || w_is_scr || w_is_rdc);

    always_comb begin
        w_id_word = '0;
        for (int k = 0; k < NUM_ID; k++) begin
            if (w_idx == IDX_W'(k)) begin
                w_id_word = ID_INIT[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_is_id) begin
            w_rdata = w_id_word;
        end else if (w_is_scr) begin
            w_rdata = r_scratch;
        end else if (w_is_rdc) begin
            w_rdata = r_rdcount;
        end
    end

    assign PREADY  = (r_state == S_ACCESS) && (r_cnt == 3'd0);
    assign PSLVERR = PREADY && r_err;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= S_IDLE;
            r_cnt     <= 3'd0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            PRDATA    <= '0;
            r_scratch <= '0;
            r_rdcount <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        r_state <= S_ACCESS;
                        r_cnt   <= 3'(WAIT_STATES);
                        r_write <= PWRITE;
                        r_err   <= w_err;
                        PRDATA  <= PWRITE ? '0 : w_rdata;
                    end
                end
                S_ACCESS: begin
                    if (!PSEL) begin
                        r_state <= S_IDLE;
                    end else if (PENABLE && PREADY) begin
                        r_state <= S_IDLE;
                        if (!r_err) begin
                            if (r_write) begin
                                r_scratch <= PWDATA;
                            end else begin
                                r_rdcount <= r_rdcount + DATA_W'(1);
                            end
                        end
                    end else if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
